// File: rtl/chess_clock_multi.sv
// chess_clock_multi
//   Multi-player (2..8) game clock. Each player owns a seconds counter that
//   counts down only while that player is active. A turn press rotates the
//   move round-robin and, when CHESS_CLOCK_INCREMENT_EN is defined, adds a
//   Fischer increment to the player who just moved.
//
//   Optional feature macro: CHESS_CLOCK_INCREMENT_EN
//
// Ports
//   i_clk_50m   system clock
//   i_rst       asynchronous active-high reset
//   i_start     one-cycle pulse: load times and start the game
//   i_turn      one-cycle pulse: active player ends the move
//   i_pause     level: freezes the clock while high
//   i_init_sec  initial seconds per player (sampled on i_start)
//   i_inc_sec   Fischer increment in seconds (sampled on i_start)
//   o_time      flat time bus, player k at [k*P_TIME_W +: P_TIME_W]
//   o_active    one-hot active player
//   o_flag      sticky out-of-time flags
//   o_running   high while in RUN
module chess_clock_multi #(
  parameter int P_PLAYERS = 2,
  parameter int P_DIVIDER = 50_000_000,
  parameter int P_TIME_W  = 13
) (
  input  logic                            i_clk_50m,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic                            i_turn,
  input  logic                            i_pause,
  input  logic [P_TIME_W-1:0]             i_init_sec,
  input  logic [7:0]                      i_inc_sec,
  output logic [P_PLAYERS*P_TIME_W-1:0]   o_time,
  output logic [P_PLAYERS-1:0]            o_active,
  output logic [P_PLAYERS-1:0]            o_flag,
  output logic                            o_running
);

  localparam int PW = (P_DIVIDER > 1) ? $clog2(P_DIVIDER) : 1;
  localparam int AW = $clog2(P_PLAYERS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FLAG} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [P_TIME_W-1:0]   time_q [P_PLAYERS];
  logic [P_TIME_W-1:0]   time_d [P_PLAYERS];
  logic [AW-1:0]         act_q, act_d;
  logic [P_PLAYERS-1:0]  active_q;
  logic [P_PLAYERS-1:0]  flag_q, flag_d;
  logic                  running_q;

  logic                  tick;
  logic [P_TIME_W:0]     cur_ext;
  logic [P_TIME_W:0]     dec_ext;
  logic [P_TIME_W-1:0]   turn_time;
  logic [AW-1:0]         act_next;

`ifdef CHESS_CLOCK_INCREMENT_EN
  logic [7:0]            inc_q, inc_d;
  logic [P_TIME_W:0]     sum_ext;
`else
  logic                  unused_inc;
  assign unused_inc = ^i_inc_sec;
`endif

  always_comb begin
    tick     = (state_q == RUN) && !i_pause && (presc_q == PW'(P_DIVIDER - 1));
    cur_ext  = {1'b0, time_q[act_q]};
    // Decrement saturates at 0 so a zero load flags instead of wrapping.
    dec_ext  = (tick && (cur_ext != '0)) ? cur_ext - 1'b1 : cur_ext;
    act_next = (act_q == AW'(P_PLAYERS - 1)) ? '0 : act_q + 1'b1;
`ifdef CHESS_CLOCK_INCREMENT_EN
    sum_ext   = dec_ext + (P_TIME_W + 1)'(inc_q);
    turn_time = sum_ext[P_TIME_W] ? '1 : sum_ext[P_TIME_W-1:0];
`else
    turn_time = dec_ext[P_TIME_W-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    time_d  = time_q;
    act_d   = act_q;
    flag_d  = flag_q;
`ifdef CHESS_CLOCK_INCREMENT_EN
    inc_d   = inc_q;
`endif
    if (i_start) begin
      for (int unsigned k = 0; k < P_PLAYERS; k++) time_d[k] = i_init_sec;
`ifdef CHESS_CLOCK_INCREMENT_EN
      inc_d   = i_inc_sec;
`endif
      flag_d  = '0;
      act_d   = '0;
      presc_d = '0;
      state_d = i_pause ? PAUSE : RUN;
    end else begin
      unique case (state_q)
        IDLE: presc_d = '0;
        RUN: begin
          if (i_pause) begin
            state_d = PAUSE;
          end else if (dec_ext == '0) begin
            // Running out of time beats a simultaneous turn.
            time_d[act_q] = '0;
            flag_d[act_q] = 1'b1;
            state_d       = FLAG;
          end else if (i_turn) begin
            time_d[act_q] = turn_time;
            act_d         = act_next;
            presc_d       = '0;
          end else begin
            time_d[act_q] = dec_ext[P_TIME_W-1:0];
            presc_d       = tick ? '0 : presc_q + 1'b1;
          end
        end
        PAUSE: if (!i_pause) state_d = RUN;
        FLAG:  ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk_50m or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      time_q    <= '{default: '0};
      act_q     <= '0;
      active_q  <= P_PLAYERS'(1);
      flag_q    <= '0;
      running_q <= 1'b0;
`ifdef CHESS_CLOCK_INCREMENT_EN
      inc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      time_q    <= time_d;
      act_q     <= act_d;
      active_q  <= P_PLAYERS'(1) << act_d;
      flag_q    <= flag_d;
      running_q <= (state_d == RUN);
`ifdef CHESS_CLOCK_INCREMENT_EN
      inc_q     <= inc_d;
`endif
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < P_PLAYERS; k++) o_time[k*P_TIME_W +: P_TIME_W] = time_q[k];
  end

  assign o_active  = active_q;
  assign o_flag    = flag_q;
  assign o_running = running_q;

endmodule

// File: tb/tb_chess_clock_multi.sv
module tb_chess_clock_multi;

`ifdef CHESS_CLOCK_INCREMENT_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, turn, pause;
  logic [12:0] init_sec;
  logic [7:0]  inc_sec;

  logic [25:0] t2;
  logic [1:0]  a2, f2;
  logic        r2;
  logic [38:0] t3;
  logic [2:0]  a3, f3;
  logic        r3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chess_clock_multi #(.P_PLAYERS(2), .P_DIVIDER(4), .P_TIME_W(13)) u2 (
    .i_clk_50m(clk), .i_rst(rst), .i_start(start), .i_turn(turn), .i_pause(pause),
    .i_init_sec(init_sec), .i_inc_sec(inc_sec),
    .o_time(t2), .o_active(a2), .o_flag(f2), .o_running(r2));

  chess_clock_multi #(.P_PLAYERS(3), .P_DIVIDER(4), .P_TIME_W(13)) u3 (
    .i_clk_50m(clk), .i_rst(rst), .i_start(start), .i_turn(turn), .i_pause(pause),
    .i_init_sec(init_sec), .i_inc_sec(inc_sec),
    .o_time(t3), .o_active(a3), .o_flag(f3), .o_running(r3));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] p3(input int k);
    return t3[k*13 +: 13];
  endfunction

  function automatic logic [12:0] p2(input int k);
    return t2[k*13 +: 13];
  endfunction

  task automatic do_start(input logic [12:0] init, input logic [7:0] inc);
    init_sec = init;
    inc_sec  = inc;
    start    = 1'b1;
    step(1);
    start    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; turn = 1'b0; pause = 1'b0;
    init_sec = '0; inc_sec = '0;

    // Reset and idle
    step(2);
    chk("rst_time2", t2, 0);
    chk("rst_act2", a2, 2'b01);
    chk("rst_flag2", f2, 0);
    chk("rst_run2", r2, 0);
    chk("rst_act3", a3, 3'b001);
    rst = 1'b0;
    step(1);
    turn = 1'b1; step(1); turn = 1'b0; step(1);
    chk("idle_turn_act2", a2, 2'b01);
    chk("idle_turn_time2", t2, 0);
    chk("idle_turn_run2", r2, 0);

    // Countdown to flag, 3 players, init=3
    do_start(13'd3, 8'd0);
    chk("cd_load_p0", p3(0), 3);
    chk("cd_load_p2", p3(2), 3);
    chk("cd_run", r3, 1);
    chk("cd_act", a3, 3'b001);
    step(3);
    chk("cd_before_tick", p3(0), 3);
    step(1);
    chk("cd_tick1", p3(0), 2);
    step(4);
    chk("cd_tick2", p3(0), 1);
    step(4);
    chk("cd_zero", p3(0), 0);
    chk("cd_flag", f3, 3'b001);
    chk("cd_run_off", r3, 0);
    turn = 1'b1; step(1); turn = 1'b0; step(1);
    chk("cd_turn_ignored", a3, 3'b001);
    chk("cd_flag_sticky", f3, 3'b001);

    // Increment, 2 players, init=5 inc=2, turn sampled 5 cycles after start
    do_start(13'd5, 8'd2);
    step(4);
    chk("inc_tick", p2(0), 4);
    turn = 1'b1; step(1); turn = 1'b0;
    chk("inc_p0", p2(0), INC_EN ? 6 : 4);
    chk("inc_p1", p2(1), 5);
    chk("inc_act", a2, 2'b10);

    // Round-robin wrap and saturation, 3 players
    do_start(13'd8190, 8'd5);
    turn = 1'b1;
    step(1);
    chk("sat_act1", a3, 3'b010);
    chk("sat_p0", p3(0), INC_EN ? 8191 : 8190);
    step(1);
    chk("sat_act2", a3, 3'b100);
    chk("sat_p1", p3(1), INC_EN ? 8191 : 8190);
    step(1);
    turn = 1'b0;
    chk("sat_act_wrap", a3, 3'b001);
    chk("sat_p2", p3(2), INC_EN ? 8191 : 8190);

    // Pause mid-second: prescaler at 2 when frozen
    do_start(13'd10, 8'd0);
    step(2);
    pause = 1'b1;
    step(1);
    chk("pause_run_off", r3, 0);
    step(19);
    chk("pause_time_held", p3(0), 10);
    chk("pause_run_still_off", r3, 0);
    pause = 1'b0;
    step(1);
    chk("resume_run", r3, 1);
    step(1);
    chk("resume_no_tick_yet", p3(0), 10);
    step(1);
    chk("resume_tick", p3(0), 9);

    // Collision: turn on the tick that takes time to zero
    do_start(13'd1, 8'd3);
    step(3);
    chk("col_before", p3(0), 1);
    turn = 1'b1; step(1); turn = 1'b0;
    chk("col_flag", f3, 3'b001);
    chk("col_act", a3, 3'b001);
    chk("col_time", p3(0), 0);
    chk("col_run", r3, 0);
    do_start(13'd2, 8'd0);
    chk("restart_flag", f3, 0);
    chk("restart_act", a3, 3'b001);
    chk("restart_p2", p3(2), 2);
    chk("restart_run", r3, 1);

    // Zero initial time flags on the following cycle
    do_start(13'd0, 8'd0);
    chk("zero_run", r3, 1);
    chk("zero_noflag_yet", f3, 0);
    step(1);
    chk("zero_flag3", f3, 3'b001);
    chk("zero_flag2", f2, 2'b01);
    chk("zero_run_off", r3, 0);

    // Asynchronous reset mid-game
    do_start(13'd7, 8'd0);
    step(1);
    #2 rst = 1'b1;
    #1;
    chk("arst_time", t3, 0);
    chk("arst_act", a3, 3'b001);
    chk("arst_run", r3, 0);
    rst = 1'b0;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
